// File: rtl/vp_timing_regen.sv
`default_nettype none
// ============================================================================
// Module   : vp_timing_regen
// Purpose  : Buffers a bursty RGB565 stream and replays it as a clean raster
//            with hs/vs/de driven by a free-running H/V timing generator.
// Revision : 1.0 - initial release
// ============================================================================
module vp_timing_regen #(
    parameter int H_DISP      = 1280,
    parameter int H_FP        = 110,
    parameter int H_SYNC      = 40,
    parameter int H_BP        = 220,
    parameter int V_DISP      = 720,
    parameter int V_FP        = 5,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 20,
    parameter int FIFO_AW     = 11,
    parameter int START_LEVEL = 1024,
    parameter bit SYNC_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vs_i,
    input  logic        de_i,
    input  logic [15:0] data_i,
    output logic        hs_o,
    output logic        vs_o,
    output logic        de_o,
    output logic [15:0] data_o,
    output logic        running_o,
    output logic        underflow_o,
    output logic        overflow_o
);

    localparam int c_H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_DEPTH   = 2 ** FIFO_AW;
    localparam int c_LW      = FIFO_AW + 1;

    // Inclusive bounds so no constant has to represent the total itself
    localparam logic [c_HW-1:0] c_H_ACT_L  = c_HW'(H_DISP - 1);
    localparam logic [c_HW-1:0] c_H_SYNC_F = c_HW'(H_DISP + H_FP);
    localparam logic [c_HW-1:0] c_H_SYNC_L = c_HW'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [c_HW-1:0] c_H_LAST   = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_ACT_L  = c_VW'(V_DISP - 1);
    localparam logic [c_VW-1:0] c_V_SYNC_F = c_VW'(V_DISP + V_FP);
    localparam logic [c_VW-1:0] c_V_SYNC_L = c_VW'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic [c_VW-1:0] c_V_LAST   = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_LW-1:0] c_FULL     = c_LW'(c_DEPTH);
    localparam logic [c_LW-1:0] c_START    = c_LW'(START_LEVEL);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_FILL = 2'd1;
    localparam logic [1:0] c_S_RUN  = 2'd2;

    logic [1:0]         r_state;
    logic               r_vs_q;
    logic [c_HW-1:0]    r_h_cnt;
    logic [c_VW-1:0]    r_v_cnt;
    logic               r_err_frame;
    logic [15:0]        r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0]    r_level;
    logic               r_underflow;
    logic               r_overflow;
    logic               r_hs;
    logic               r_vs;
    logic               r_de;
    logic [15:0]        r_data;

    logic w_vs_edge;
    logic w_run;
    logic w_flush;
    logic w_full;
    logic w_empty;
    logic w_active;
    logic w_hs_act;
    logic w_vs_act;
    logic w_h_last;
    logic w_frame_end;
    logic w_wr;
    logic w_ovf;
    logic w_rd;
    logic w_unf;

    assign w_vs_edge   = vs_i & ~r_vs_q;
    assign w_run       = (r_state == c_S_RUN);
    // A new frame only restarts buffering before the raster is running
    assign w_flush     = w_vs_edge && !w_run;
    assign w_full      = (r_level == c_FULL);
    assign w_empty     = (r_level == '0);
    assign w_h_last    = (r_h_cnt == c_H_LAST);
    assign w_frame_end = w_run && w_h_last && (r_v_cnt == c_V_LAST);
    assign w_active    = w_run && (r_h_cnt <= c_H_ACT_L) && (r_v_cnt <= c_V_ACT_L);
    assign w_hs_act    = w_run && (r_h_cnt >= c_H_SYNC_F) && (r_h_cnt <= c_H_SYNC_L);
    assign w_vs_act    = w_run && (r_v_cnt >= c_V_SYNC_F) && (r_v_cnt <= c_V_SYNC_L);
    assign w_wr        = de_i && !w_full && (r_state != c_S_IDLE) && !w_flush;
    assign w_ovf       = de_i &&  w_full && (r_state != c_S_IDLE) && !w_flush;
    assign w_rd        = w_active && !w_empty;
    assign w_unf       = w_active &&  w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_S_IDLE;
            r_vs_q      <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_vs_q <= vs_i;
            if (w_frame_end) begin
                r_err_frame <= 1'b0;
            end else if (w_unf) begin
                r_err_frame <= 1'b1;
            end
            case (r_state)
                c_S_IDLE: if (w_vs_edge) r_state <= c_S_FILL;
                c_S_FILL: if (!w_vs_edge && (r_level >= c_START)) r_state <= c_S_RUN;
                c_S_RUN:  if (w_frame_end && r_err_frame) r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (!w_run) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_last) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + c_VW'(1);
        end else begin
            r_h_cnt <= r_h_cnt + c_HW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_underflow <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + c_LW'(1);
                2'b01:   r_level <= r_level - c_LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_unf) r_underflow <= 1'b1;
            if (w_ovf) r_overflow  <= 1'b1;
        end
    end

    // Sync/de decode shares the one-clock latency of the FIFO read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hs   <= ~SYNC_POL;
            r_vs   <= ~SYNC_POL;
            r_de   <= 1'b0;
            r_data <= '0;
        end else begin
            r_hs   <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vs   <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_de   <= w_active;
            r_data <= w_rd ? r_mem[r_rd_ptr] : 16'h0000;
        end
    end

    assign hs_o        = r_hs;
    assign vs_o        = r_vs;
    assign de_o        = r_de;
    assign data_o      = r_data;
    assign running_o   = w_run;
    assign underflow_o = r_underflow;
    assign overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_vp_timing_regen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vp_timing_regen
// Purpose  : Directed bench for vp_timing_regen on a 14x7 raster, 16-deep FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vp_timing_regen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vs_i;
    logic        de_i;
    logic [15:0] data_i;
    logic        hs_o;
    logic        vs_o;
    logic        de_o;
    logic [15:0] data_o;
    logic        running_o;
    logic        underflow_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;
    int s      = 0;
    // Step at which raster cycle (h=0,v=0) of the current run shows on the outputs
    int base   = 1000000;
    logic [15:0] pix_base [2];
    int          pix_cnt  [2];

    vp_timing_regen #(
        .H_DISP      (8),
        .H_FP        (2),
        .H_SYNC      (2),
        .H_BP        (2),
        .V_DISP      (4),
        .V_FP        (1),
        .V_SYNC      (1),
        .V_BP        (1),
        .FIFO_AW     (4),
        .START_LEVEL (4),
        .SYNC_POL    (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vs_i        (vs_i),
        .de_i        (de_i),
        .data_i      (data_i),
        .hs_o        (hs_o),
        .vs_o        (vs_o),
        .de_o        (de_o),
        .data_o      (data_o),
        .running_o   (running_o),
        .underflow_o (underflow_o),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_pix(input logic [15:0] d);
        de_i   = 1'b1;
        data_i = d;
    endtask

    task automatic idle_pix();
        de_i   = 1'b0;
        data_i = 16'h0000;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, s, obs, exp);
        end
    endtask

    // Expected raster outputs for the step: 14 clocks/line, 7 lines/frame
    task automatic check_raster(input int k);
        int c, h, v, f, j;
        logic e_de, e_hs, e_vs;
        logic [15:0] e_data;
        c = k - base;
        e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_data = 16'h0000;
        if (c >= 0) begin
            f    = c / 98;
            h    = c % 14;
            v    = (c / 14) % 7;
            j    = v * 8 + h;
            e_de = (h < 8) && (v < 4);
            e_hs = (h >= 10) && (h < 12);
            e_vs = (v == 5);
            if (e_de && f < 2 && j < pix_cnt[f]) e_data = pix_base[f] + 16'(j);
        end
        check("de_o", de_o, e_de);
        check("hs_o", hs_o, e_hs);
        check("vs_o", vs_o, e_vs);
        check("data_o", data_o, e_data);
    endtask

    initial begin
        rst_n = 1'b0;
        vs_i  = 1'b0;
        idle_pix();
        tick(); tick(); tick();
        check("rst_de_o", de_o, 1'b0);
        check("rst_hs_o", hs_o, 1'b0);
        check("rst_vs_o", vs_o, 1'b0);
        check("rst_data_o", data_o, 16'h0000);
        check("rst_running_o", running_o, 1'b0);
        check("rst_underflow_o", underflow_o, 1'b0);
        check("rst_overflow_o", overflow_o, 1'b0);
        rst_n = 1'b1;
        tick(); tick();

        // Start, full-rate frame, vs rise in RUN, then a 6-pixel frame that underflows
        base = 7;
        pix_base[0] = 16'h0001; pix_cnt[0] = 32;
        pix_base[1] = 16'h0101; pix_cnt[1] = 6;
        for (int k = 1; k <= 210; k++) begin
            s    = k;
            vs_i = (k < 40) || (k >= 45);
            if (k >= 2 && k <= 33)       drive_pix(16'(k - 1));
            else if (k >= 61 && k <= 66) drive_pix(16'h0100 + 16'(k - 60));
            else                         idle_pix();
            tick();
            if (k == 203) base = 1000000;
            check_raster(k);
            check("running_o", running_o, (k >= 6) && (k <= 201));
            check("underflow_o", underflow_o, k >= 111);
            check("overflow_o", overflow_o, 1'b0);
        end

        // Re-flush in FILL, full-rate frame, 20-pixel burst in vertical blank
        base = 223;
        pix_base[0] = 16'h0201; pix_cnt[0] = 32;
        pix_base[1] = 16'h0301; pix_cnt[1] = 16;
        for (int k = 211; k <= 365; k++) begin
            s    = k;
            vs_i = (k >= 212 && k <= 215) || (k >= 217);
            if (k >= 213 && k <= 215)      drive_pix(16'h0AA0 + 16'(k - 212));
            else if (k >= 218 && k <= 249) drive_pix(16'h0200 + 16'(k - 217));
            else if (k >= 275 && k <= 294) drive_pix(16'h0300 + 16'(k - 274));
            else                           idle_pix();
            tick();
            check_raster(k);
            check("running_o", running_o, k >= 222);
            check("underflow_o", underflow_o, (k <= 211) || (k >= 349));
            check("overflow_o", overflow_o, k >= 291);
        end

        // Asynchronous reset in the middle of an active line
        s     = 366;
        rst_n = 1'b0;
        vs_i  = 1'b0;
        idle_pix();
        #1;
        check("arst_de_o", de_o, 1'b0);
        check("arst_hs_o", hs_o, 1'b0);
        check("arst_vs_o", vs_o, 1'b0);
        check("arst_data_o", data_o, 16'h0000);
        check("arst_running_o", running_o, 1'b0);
        check("arst_underflow_o", underflow_o, 1'b0);
        check("arst_overflow_o", overflow_o, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check("post_rst_running_o", running_o, 1'b0);
        check("post_rst_de_o", de_o, 1'b0);

        // Normal restart after reset; four pixels only, so pixel 5 underflows
        base = 7;
        pix_base[0] = 16'h0401; pix_cnt[0] = 4;
        pix_base[1] = 16'h0000; pix_cnt[1] = 0;
        for (int k = 1; k <= 14; k++) begin
            s    = k;
            vs_i = 1'b1;
            if (k >= 2 && k <= 5) drive_pix(16'h0400 + 16'(k - 1));
            else                  idle_pix();
            tick();
            check_raster(k);
            check("running_o", running_o, k >= 6);
            check("underflow_o", underflow_o, k >= 11);
            check("overflow_o", overflow_o, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
